// File: rtl/backprop_pkg.sv
// backprop_pkg
// Shared definitions for the backprop bundle sequencer: the sequencer state
// encoding and the bit layout of the 66-bit backprop control bundle.
//   bundle[65]    is_store     one store beat for (layer, row)
//   bundle[64]    start_train  single command that kicks off training
//   bundle[63:32] layer index
//   bundle[31:0]  row index
package backprop_pkg;

    localparam int BACKPROP_CONTROLL_SIZE = 66;
    localparam int IS_STORE_BIT           = 65;
    localparam int START_TRAIN_BIT        = 64;
    localparam int LAYER_MSB              = 63;
    localparam int ROW_MSB                = 31;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_STORE       = 3'd1,
        ST_TRAIN_START = 3'd2,
        ST_TRAIN_WAIT  = 3'd3,
        ST_DONE        = 3'd4
    } state_t;

endpackage

// File: rtl/layer_row_counter.sv
// layer_row_counter
// Nested row/layer counter. The row counts up to the row count of the current
// layer, then wraps to 0 and bumps the layer. o_last flags the final row of the
// final layer, so the owner can leave the store phase on that beat.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   i_clear         zero both counters (start of a sequence)
//   i_en            advance by one beat
//   i_num_layers    number of layers in use (latched config)
//   i_layer_rows    packed per-layer row counts, layer i at [32*i+31:32*i]
//   o_layer, o_row  current (layer, row) position
//   o_last          current position is the last beat of the sequence
module layer_row_counter #(
    parameter int MAX_LAYER_SIZE = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_clear,
    input  logic                        i_en,
    input  logic [31:0]                 i_num_layers,
    input  logic [32*MAX_LAYER_SIZE-1:0] i_layer_rows,
    output logic [31:0]                 o_layer,
    output logic [31:0]                 o_row,
    output logic                        o_last
);

    logic [31:0] r_layer;
    logic [31:0] r_row;
    logic [31:0] w_rows_cur;
    logic        w_last_row;
    logic        w_last_layer;

    // Row count of the layer currently being walked.
    always_comb begin
        w_rows_cur = '0;
        for (int unsigned i = 0; i < MAX_LAYER_SIZE; i++) begin
            if (r_layer == i) begin
                w_rows_cur = i_layer_rows[32*i +: 32];
            end
        end
    end

    assign w_last_row   = (r_row == w_rows_cur - 32'd1);
    assign w_last_layer = (r_layer == i_num_layers - 32'd1);
    assign o_last       = w_last_row && w_last_layer;
    assign o_layer      = r_layer;
    assign o_row        = r_row;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_layer <= '0;
            r_row   <= '0;
        end else if (i_en) begin
            if (w_last_row) begin
                r_row   <= '0;
                // Wrap the layer too after the final beat so the counter idles at (0,0).
                r_layer <= w_last_layer ? 32'd0 : r_layer + 32'd1;
            end else begin
                r_row <= r_row + 32'd1;
            end
        end
    end

endmodule

// File: rtl/backprop_bundle_sequencer.sv
// backprop_bundle_sequencer
// Drives the backprop stack controller: emits one store beat per (layer, row)
// of the latched configuration, then a single start_train command, then waits
// for train_done before reporting completion.
// Ports:
//   clk, reset                clock, synchronous active-high reset
//   start                     begin a sequence (only honoured in IDLE)
//   num_layers, layer_rows    configuration, latched on an accepted start
//   hold                      stall from the stack side
//   train_done                training complete pulse (only honoured in TRAIN_WAIT)
//   backprop_controll_bundle  registered {is_store, start_train, layer, row}
//   busy                      registered, high while a sequence is in flight
//   done                      one-cycle completion pulse
//   error                     one-cycle pulse for a rejected start
module backprop_bundle_sequencer
    import backprop_pkg::*;
#(
    parameter int max_layer_size         = 4,
    parameter int backprop_controll_size = BACKPROP_CONTROLL_SIZE
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [31:0]                   num_layers,
    input  logic [32*max_layer_size-1:0]  layer_rows,
    input  logic                          hold,
    input  logic                          train_done,
    output logic [backprop_controll_size-1:0] backprop_controll_bundle,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    state_t                         r_state;
    logic [31:0]                    r_num_layers;
    logic [32*max_layer_size-1:0]   r_layer_rows;
    logic [backprop_controll_size-1:0] r_bundle;
    logic                           r_busy;
    logic                           r_done;
    logic                           r_error;

    logic        w_cfg_valid;
    logic        w_accept;
    logic        w_cnt_en;
    logic [31:0] w_layer;
    logic [31:0] w_row;
    logic        w_last;

    // Valid when 1 <= num_layers <= max and every used layer has at least one row.
    always_comb begin
        w_cfg_valid = (num_layers != 32'd0) && (num_layers <= 32'(max_layer_size));
        for (int unsigned i = 0; i < max_layer_size; i++) begin
            if ((i < num_layers) && (layer_rows[32*i +: 32] == 32'd0)) begin
                w_cfg_valid = 1'b0;
            end
        end
    end

    assign w_accept = (r_state == ST_IDLE) && start && w_cfg_valid;
    assign w_cnt_en = (r_state == ST_STORE) && !hold;

    layer_row_counter #(
        .MAX_LAYER_SIZE (max_layer_size)
    ) u_counter (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_accept),
        .i_en         (w_cnt_en),
        .i_num_layers (r_num_layers),
        .i_layer_rows (r_layer_rows),
        .o_layer      (w_layer),
        .o_row        (w_row),
        .o_last       (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_num_layers <= '0;
            r_layer_rows <= '0;
            r_bundle     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            // busy trails the state by one edge so it rises together with the first beat.
            r_busy  <= (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    r_bundle <= '0;
                    if (start) begin
                        if (w_cfg_valid) begin
                            r_num_layers <= num_layers;
                            r_layer_rows <= layer_rows;
                            r_state      <= ST_STORE;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                ST_STORE: begin
                    if (!hold) begin
                        r_bundle <= {1'b1, 1'b0, w_layer, w_row};
                        if (w_last) begin
                            r_state <= ST_TRAIN_START;
                        end
                    end else begin
                        // Held: drop the flags, keep the last layer/row on the bus.
                        r_bundle[IS_STORE_BIT]    <= 1'b0;
                        r_bundle[START_TRAIN_BIT] <= 1'b0;
                    end
                end
                ST_TRAIN_START: begin
                    if (!hold) begin
                        r_bundle <= '0;
                        r_bundle[START_TRAIN_BIT]        <= 1'b1;
                        r_bundle[LAYER_MSB:ROW_MSB+1]    <= r_num_layers - 32'd1;
                        r_state                          <= ST_TRAIN_WAIT;
                    end else begin
                        r_bundle[IS_STORE_BIT]    <= 1'b0;
                        r_bundle[START_TRAIN_BIT] <= 1'b0;
                    end
                end
                ST_TRAIN_WAIT: begin
                    r_bundle <= '0;
                    if (train_done) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_bundle <= '0;
                    r_done   <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_bundle <= '0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign backprop_controll_bundle = r_bundle;
    assign busy                     = r_busy;
    assign done                     = r_done;
    assign error                    = r_error;

endmodule

// File: tb/tb_backprop_bundle_sequencer.sv
// Table-driven bench for backprop_bundle_sequencer. Each vector gives the inputs
// sampled at one clock edge and the outputs expected just after that edge.
module tb_backprop_bundle_sequencer;

    logic         clk;
    logic         reset;
    logic         start;
    logic [31:0]  num_layers;
    logic [127:0] layer_rows;
    logic         hold;
    logic         train_done;
    logic [65:0]  bundle;
    logic         busy;
    logic         done;
    logic         error;

    int checks   = 0;
    int failures = 0;

    backprop_bundle_sequencer #(
        .max_layer_size         (4),
        .backprop_controll_size (66)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .start                    (start),
        .num_layers               (num_layers),
        .layer_rows               (layer_rows),
        .hold                     (hold),
        .train_done               (train_done),
        .backprop_controll_bundle (bundle),
        .busy                     (busy),
        .done                     (done),
        .error                    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           scen;
        int           cyc;
        logic         start;
        logic         hold;
        logic         tdone;
        logic [31:0]  nl;
        logic [127:0] rows;
        logic [65:0]  exp_bundle;
        logic         exp_busy;
        logic         exp_done;
        logic         exp_err;
    } vec_t;

    vec_t         vecs[$];
    int           cur_scen;
    int           cur_cyc;
    logic [31:0]  cur_nl;
    logic [127:0] cur_rows;

    function automatic logic [127:0] r4(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [65:0] bs(input logic [31:0] l, input logic [31:0] r);
        return {1'b1, 1'b0, l, r};
    endfunction

    function automatic logic [65:0] bt(input logic [31:0] l);
        return {1'b0, 1'b1, l, 32'd0};
    endfunction

    function automatic logic [65:0] bh(input logic [31:0] l, input logic [31:0] r);
        return {1'b0, 1'b0, l, r};
    endfunction

    task automatic new_scen(input int s, input logic [31:0] nl, input logic [127:0] rows);
        cur_scen = s;
        cur_cyc  = 0;
        cur_nl   = nl;
        cur_rows = rows;
    endtask

    task automatic add(input logic st, input logic hd, input logic td, input logic [65:0] eb,
                       input logic bz, input logic dn, input logic er);
        vec_t v;
        v.scen = cur_scen; v.cyc = cur_cyc;
        v.start = st; v.hold = hd; v.tdone = td;
        v.nl = cur_nl; v.rows = cur_rows;
        v.exp_bundle = eb; v.exp_busy = bz; v.exp_done = dn; v.exp_err = er;
        vecs.push_back(v);
        cur_cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [65:0] eb, input logic bz,
                             input logic dn, input logic er);
        check({tag, "_bundle"}, bundle, eb);
        check({tag, "_busy"}, 66'(busy), 66'(bz));
        check({tag, "_done"}, 66'(done), 66'(dn));
        check({tag, "_error"}, 66'(error), 66'(er));
    endtask

    localparam logic [65:0] Z = 66'd0;

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        num_layers = 32'd0;
        layer_rows = '0;
        hold       = 1'b0;
        train_done = 1'b0;

        // Scenario 1: 2 layers, rows {3,2}, no hold.
        new_scen(1, 32'd2, r4(32'd3, 32'd2, 32'd0, 32'd0));
        add(1, 0, 0, Z, 0, 0, 0);
        add(0, 0, 0, bs(0, 0), 1, 0, 0);
        add(0, 0, 0, bs(0, 1), 1, 0, 0);
        add(0, 0, 0, bs(0, 2), 1, 0, 0);
        add(0, 0, 0, bs(1, 0), 1, 0, 0);
        add(0, 0, 0, bs(1, 1), 1, 0, 0);
        add(0, 0, 0, bt(1), 1, 0, 0);
        add(0, 0, 0, Z, 1, 0, 0);
        add(0, 0, 0, Z, 1, 0, 0);
        add(0, 0, 1, Z, 1, 0, 0);
        add(0, 0, 0, Z, 1, 1, 0);
        add(0, 0, 0, Z, 0, 0, 0);

        // Scenario 2: same config, hold during cycles 2-3.
        new_scen(2, 32'd2, r4(32'd3, 32'd2, 32'd0, 32'd0));
        add(1, 0, 0, Z, 0, 0, 0);
        add(0, 0, 0, bs(0, 0), 1, 0, 0);
        add(0, 1, 0, bh(0, 0), 1, 0, 0);
        add(0, 1, 0, bh(0, 0), 1, 0, 0);
        add(0, 0, 0, bs(0, 1), 1, 0, 0);
        add(0, 0, 0, bs(0, 2), 1, 0, 0);
        add(0, 0, 0, bs(1, 0), 1, 0, 0);
        add(0, 0, 0, bs(1, 1), 1, 0, 0);
        add(0, 0, 0, bt(1), 1, 0, 0);
        add(0, 0, 0, Z, 1, 0, 0);
        add(0, 0, 1, Z, 1, 0, 0);
        add(0, 0, 0, Z, 1, 1, 0);
        add(0, 0, 0, Z, 0, 0, 0);

        // Scenario 3: spurious train_done and start during STORE, holds that
        // freeze non-zero fields, and a hold on TRAIN_START.
        new_scen(3, 32'd2, r4(32'd3, 32'd2, 32'd0, 32'd0));
        add(1, 0, 0, Z, 0, 0, 0);
        add(0, 0, 0, bs(0, 0), 1, 0, 0);
        add(0, 0, 1, bs(0, 1), 1, 0, 0);
        cur_nl = 32'd1; cur_rows = r4(32'd1, 32'd1, 32'd1, 32'd1);
        add(1, 0, 0, bs(0, 2), 1, 0, 0);
        add(0, 1, 0, bh(0, 2), 1, 0, 0);
        add(0, 0, 0, bs(1, 0), 1, 0, 0);
        add(0, 0, 0, bs(1, 1), 1, 0, 0);
        add(0, 1, 0, bh(1, 1), 1, 0, 0);
        add(0, 0, 0, bt(1), 1, 0, 0);
        add(0, 0, 0, Z, 1, 0, 0);
        add(0, 0, 1, Z, 1, 0, 0);
        add(0, 0, 0, Z, 1, 1, 0);
        add(0, 0, 0, Z, 0, 0, 0);

        // Scenario 4: rejected configurations.
        new_scen(4, 32'd0, r4(32'd3, 32'd2, 32'd0, 32'd0));
        add(1, 0, 0, Z, 0, 0, 1);
        add(0, 0, 0, Z, 0, 0, 0);
        new_scen(5, 32'd5, r4(32'd3, 32'd2, 32'd1, 32'd1));
        add(1, 0, 0, Z, 0, 0, 1);
        add(0, 0, 0, Z, 0, 0, 0);
        new_scen(6, 32'd2, r4(32'd3, 32'd0, 32'd1, 32'd1));
        add(1, 0, 0, Z, 0, 0, 1);
        add(0, 0, 0, Z, 0, 0, 0);

        // Scenario 7: four layers of one row each.
        new_scen(7, 32'd4, r4(32'd1, 32'd1, 32'd1, 32'd1));
        add(1, 0, 0, Z, 0, 0, 0);
        add(0, 0, 0, bs(0, 0), 1, 0, 0);
        add(0, 0, 0, bs(1, 0), 1, 0, 0);
        add(0, 0, 0, bs(2, 0), 1, 0, 0);
        add(0, 0, 0, bs(3, 0), 1, 0, 0);
        add(0, 0, 0, bt(3), 1, 0, 0);
        add(0, 0, 0, Z, 1, 0, 0);
        add(0, 0, 1, Z, 1, 0, 0);
        add(0, 0, 0, Z, 1, 1, 0);
        add(0, 0, 0, Z, 0, 0, 0);

        // Scenario 8: single layer of four rows; unused layers with zero rows are fine.
        new_scen(8, 32'd1, r4(32'd4, 32'd0, 32'd0, 32'd0));
        add(1, 0, 0, Z, 0, 0, 0);
        add(0, 0, 0, bs(0, 0), 1, 0, 0);
        add(0, 0, 0, bs(0, 1), 1, 0, 0);
        add(0, 0, 0, bs(0, 2), 1, 0, 0);
        add(0, 0, 0, bs(0, 3), 1, 0, 0);
        add(0, 0, 0, bt(0), 1, 0, 0);
        add(0, 0, 1, Z, 1, 0, 0);
        add(0, 0, 0, Z, 1, 1, 0);
        add(0, 0, 0, Z, 0, 0, 0);

        tick();
        tick();
        check_all("reset", Z, 0, 0, 0);
        reset = 1'b0;
        tick();
        check_all("post_reset_idle", Z, 0, 0, 0);

        foreach (vecs[i]) begin
            start      = vecs[i].start;
            hold       = vecs[i].hold;
            train_done = vecs[i].tdone;
            num_layers = vecs[i].nl;
            layer_rows = vecs[i].rows;
            tick();
            check_all($sformatf("s%0d_c%0d", vecs[i].scen, vecs[i].cyc), vecs[i].exp_bundle,
                      vecs[i].exp_busy, vecs[i].exp_done, vecs[i].exp_err);
        end
        start = 1'b0; hold = 1'b0; train_done = 1'b0;

        // Reset mid-sequence, then a fresh run must restart from (0,0).
        num_layers = 32'd2;
        layer_rows = r4(32'd3, 32'd2, 32'd0, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("rst_seq_c1", bundle, bs(0, 0));
        tick();
        tick();
        check("rst_seq_c3", bundle, bs(0, 2));
        reset = 1'b1;
        tick();
        check_all("rst_seq_c4", Z, 0, 0, 0);
        reset = 1'b0;
        tick();
        check_all("rst_seq_c5", Z, 0, 0, 0);
        tick();
        check_all("rst_seq_c6", Z, 0, 0, 0);

        begin
            int          beats = 0;
            int          sts = 0;
            int          both = 0;
            bit          got_done = 0;
            bit          have_first = 0;
            bit          td_sent = 0;
            logic [65:0] first_beat = '0;
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int k = 0; k < 40 && !got_done; k++) begin
                train_done = (sts > 0) && !td_sent;
                if (train_done) td_sent = 1;
                tick();
                train_done = 1'b0;
                if (bundle[65]) begin
                    if (!have_first) first_beat = bundle;
                    have_first = 1;
                    beats++;
                end
                if (bundle[64]) sts++;
                if (bundle[65] && bundle[64]) both++;
                if (done) got_done = 1;
            end
            check("restart_first_beat", first_beat, bs(0, 0));
            check("restart_store_beats", 66'(beats), 66'd5);
            check("restart_start_train_count", 66'(sts), 66'd1);
            check("restart_flags_exclusive", 66'(both), 66'd0);
            check("restart_done_seen", 66'(got_done), 66'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/backprop_bundle_sequencer.md
# backprop_bundle_sequencer

Generates the 66-bit `backprop_controll_bundle` consumed by `backprop_stack_controller`: it sequences every (layer, row) store beat of a forward pass, then issues the single `start_train` command and waits for training to finish. It sits between the top-level training FSM and the backprop stack. It replaces the file-driven stimulus used today, so the stack is driven by real hardware.

## Interface
Parameters:
- `max_layer_size`, 4: maximum number of layers supported.
- `backprop_controll_size`, 66: bundle width. Fixed as 1 + 1 + 32 + 32.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a sequence. Sampled only in IDLE.
- `num_layers`  in  32: layer count, latched on accepted `start`.
- `layer_rows`  in  32*max_layer_size: row count of layer i at bits [32*i+31:32*i], latched on accepted `start`.
- `hold`  in  1: stall request from the stack side.
- `train_done`  in  1: one-cycle pulse signalling that backprop training has completed.
- `backprop_controll_bundle`  out  66: registered bundle. Bit 65 is `is_store`, bit 64 is `start_train`, bits [63:32] are the layer index, bits [31:0] are the row index.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when a sequence completes.
- `error`  out  1: one-cycle pulse when `start` is rejected.

## Operation
- States: IDLE, STORE, TRAIN_START, TRAIN_WAIT, DONE.
- **IDLE**
  - Bundle is all zero.
  - `start`=1 with a valid config: latch the config, clear the layer and row counters, go to STORE.
  - A config is valid when 1 ≤ `num_layers` ≤ `max_layer_size` and every used layer's `layer_rows` is ≥ 1.
  - Invalid config: pulse `error` for one cycle and stay in IDLE.
- **STORE**, each cycle:
  - `hold`=0: register bundle = {1, 0, layer, row}, then advance the counters.
    - Row increments. On the last row of a layer, row wraps to 0 and layer increments.
    - After the last row of the last layer, go to TRAIN_START.
  - `hold`=1: register `is_store`=0 and `start_train`=0. The layer and row fields keep their previous values and the counters do not move.
- **TRAIN_START**
  - `hold`=0: register bundle = {0, 1, `num_layers`-1, 0} for exactly one cycle, then go to TRAIN_WAIT.
  - `hold`=1: bundle flags stay 0 and the state does not change.
- **TRAIN_WAIT**
  - Bundle is all zero.
  - `train_done`=1: go to DONE.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
- `start` is ignored whenever `busy`=1.
- `train_done` is ignored outside TRAIN_WAIT.
- `layer_rows` and `num_layers` may change freely after latch; they do not affect a running sequence.

## Timing
- Reset values: bundle = 0, `busy`=0, `done`=0, `error`=0, state = IDLE.
- Reset asserted mid-sequence: from the next edge all outputs are at reset values. No partial `start_train` is emitted.
- Reset has priority over every other input.
- `start` accepted at edge E: `busy`=1 and the first store beat are both visible after E+1.
- The store phase emits exactly sum(`layer_rows[0..num_layers-1]`) beats with `is_store`=1, one per cycle in which `hold`=0.
- `start_train` is high after the edge that follows the last store beat, provided `hold`=0.
- `train_done` sampled at edge T: `done`=1 after T+1 and `busy`=0 after T+2.
- `error` is registered: it is high for the cycle after the rejected `start`.
- `is_store` and `start_train` are never high in the same cycle.

## Structure
- Shared package `backprop_pkg`:
  - State enum.
  - Bundle field offsets: `IS_STORE_BIT`=65, `START_TRAIN_BIT`=64, `LAYER_MSB`=63, `ROW_MSB`=31.
  - `BACKPROP_CONTROLL_SIZE`=66.
- Sub-module `layer_row_counter`: a nested row/layer counter with enable, wrap and last-beat flag, instantiated once.

## Test plan
- Config `num_layers`=2, rows {3,2}, `start` at cycle 0, no hold:
  - Cycles 1–5 carry `is_store`=1 with (layer,row) = (0,0), (0,1), (0,2), (1,0), (1,1).
  - Cycle 6 carries `start_train`=1, layer=1, row=0.
  - `train_done` at cycle 9 gives `done`=1 at cycle 10 and `busy`=0 at cycle 11.
- Same config with `hold`=1 during cycles 2–3:
  - Exactly 5 store beats, at cycles 1, 4, 5, 6, 7.
  - Layer and row fields are frozen while held.
  - `start_train` at cycle 8.
- `num_layers`=0, and separately `num_layers`=5: `error`=1 for one cycle, `busy` stays 0, bundle stays 0.
- Reset asserted at cycle 3 of the first scenario: from cycle 4 all outputs are 0. A fresh `start` afterwards restarts from (0,0).
- A `start` pulse during STORE and a spurious `train_done` during STORE are both ignored: the sequence and the beat count are unchanged.
- `num_layers`=4, rows {1,1,1,1}: store beats (0,0), (1,0), (2,0), (3,0), then `start_train` with layer=3.
